usr_param: RTL

Parametrised universal shift register, the successor to the fixed 8-bit USR. Adds width generalisation, rotate and arithmetic-shift modes, a clock enable, serial-out taps, and a counted burst-shift mode with a busy/done handshake. Used as the serialiser/deserialiser and datapath shifter in lab designs that need more than one shift per command.

---
 rtl/usr_param.sv | 90 +++++++++
 1 files changed

// File: rtl/usr_param.sv
// usr_param: parametrised universal shift register with a counted burst-shift FSM.
// Latency: 1 cycle per single-step op, N+1 cycles for an N-shift burst; no backpressure, en=0 freezes all state.
module usr_param #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] pload,
  input  logic             l_in,
  input  logic             r_in,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] out,
  output logic             so_r,
  output logic             so_l,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] out_nxt;
  logic [CNT_W-1:0] remaining, remaining_nxt;
  logic [CNT_W-1:0] cnt_clamp;

  // Requests longer than the register saturate at a full-width shift.
  assign cnt_clamp = (count > CNT_MAX) ? CNT_MAX : count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out       <= '0;
      remaining <= '0;
    end else if (en) begin
      state     <= state_nxt;
      out       <= out_nxt;
      remaining <= remaining_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    out_nxt       = out;
    remaining_nxt = remaining;
    case (state)
      IDLE: begin
        case (mode)
          3'b001:  out_nxt = {r_in, out[WIDTH-1:1]};
          3'b010:  out_nxt = {out[WIDTH-2:0], l_in};
          3'b011:  out_nxt = pload;
          3'b100:  out_nxt = {out[0], out[WIDTH-1:1]};
          3'b101:  out_nxt = {out[WIDTH-2:0], out[WIDTH-1]};
          3'b110:  out_nxt = {out[WIDTH-1], out[WIDTH-1:1]};
          3'b111: begin
            if (start) begin
              remaining_nxt = cnt_clamp;
              state_nxt     = (cnt_clamp == CNT_ZERO) ? DONE : SHIFT;
            end
          end
          default: out_nxt = out;
        endcase
      end
      SHIFT: begin
        out_nxt       = {r_in, out[WIDTH-1:1]};
        remaining_nxt = remaining - CNT_ONE;
        if (remaining == CNT_ONE) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign so_r = out[0];
  assign so_l = out[WIDTH-1];
  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule
